// File: rtl/arbiter_rr_param.sv
// Round-robin output-port arbiter with RTS/DCTS flit handshake.
// Optional cap on consecutive grants to one port while others wait.
module arbiter_rr_param #(
    parameter int NUM_PORTS = 5,
    parameter int MAX_HOLD  = 0,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 dcts,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] xbar_sel,
    output logic                 rts,
    output logic [IDX_W-1:0]     cur_port,
    output logic                 busy
);

    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE,
        SERVE
    } mode_e;

    mode_e             mode_q, mode_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic              rts_q, rts_d;

    logic [NUM_PORTS-1:0] cur_oh;
    logic                 others;
    logic [IDX_W:0]       pk;

    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_PORTS - 1) ? '0 : i + 1'b1;
    endfunction

    // Returns {found, index}; lowest offset from start wins.
    function automatic logic [IDX_W:0] pick(input logic [IDX_W-1:0]     start,
                                            input logic [NUM_PORTS-1:0] r);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (r[j]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    assign cur_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << cur_q;
    assign others = |(req & ~cur_oh);

    always_comb begin
        mode_d = mode_q;
        cur_d  = cur_q;
        ptr_d  = ptr_q;
        hc_d   = hc_q;
        rts_d  = rts_q;
        pk     = '0;
        unique case (mode_q)
            IDLE: begin
                if (|req) begin
                    pk     = pick(ptr_q, req);
                    mode_d = SERVE;
                    cur_d  = pk[IDX_W-1:0];
                    hc_d   = '0;
                end
            end
            SERVE: begin
                if (!rts_q) begin
                    rts_d = 1'b1;
                end else if (dcts) begin
                    rts_d = 1'b0;
                    if (req[cur_q] && (MAX_HOLD == 0 ||
                        int'(hc_q) + 1 < MAX_HOLD || !others)) begin
                        hc_d = (hc_q == '1) ? hc_q : hc_q + 1'b1;
                    end else begin
                        pk   = pick(nxt(cur_q), req);
                        hc_d = '0;
                        if (pk[IDX_W]) begin
                            cur_d = pk[IDX_W-1:0];
                            ptr_d = nxt(pk[IDX_W-1:0]);
                        end else begin
                            mode_d = IDLE;
                            ptr_d  = nxt(cur_q);
                        end
                    end
                end
            end
            default: mode_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= IDLE;
            cur_q  <= '0;
            ptr_q  <= '0;
            hc_q   <= '0;
            rts_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cur_q  <= cur_d;
            ptr_q  <= ptr_d;
            hc_q   <= hc_d;
            rts_q  <= rts_d;
        end
    end

    assign busy     = (mode_q == SERVE);
    assign xbar_sel = busy ? cur_oh : '0;
    assign grant    = xbar_sel & {NUM_PORTS{rts_q & dcts}};
    assign rts      = rts_q;
    assign cur_port = busy ? cur_q : '0;

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Directed bench: three arbiters (MAX_HOLD 0, 1, 3) on shared stimulus.
module tb_arbiter_rr_param;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic       dcts;

    logic [4:0] g0, x0, g1, x1, g3, x3;
    logic [2:0] c0, c1, c3;
    logic       r0, r1, r3, b0, b1, b3;

    int n_chk;
    int n_fail;

    arbiter_rr_param #(.NUM_PORTS(5), .MAX_HOLD(0)) u_h0 (
        .clk(clk), .rst_n(rst_n), .req(req), .dcts(dcts),
        .grant(g0), .xbar_sel(x0), .rts(r0), .cur_port(c0), .busy(b0)
    );
    arbiter_rr_param #(.NUM_PORTS(5), .MAX_HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req(req), .dcts(dcts),
        .grant(g1), .xbar_sel(x1), .rts(r1), .cur_port(c1), .busy(b1)
    );
    arbiter_rr_param #(.NUM_PORTS(5), .MAX_HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .req(req), .dcts(dcts),
        .grant(g3), .xbar_sel(x3), .rts(r3), .cur_port(c3), .busy(b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [4:0] r, input logic d);
        @(negedge clk);
        req  = r;
        dcts = d;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        dcts  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [4:0] bp_req [5] = '{5'b11101, 5'b00000, 5'b10100, 5'b11111, 5'b00001};
    logic [4:0] exp3   [7] = '{5'b00001, 5'b00001, 5'b00001, 5'b00100,
                               5'b00100, 5'b00100, 5'b00001};

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req    = '0;
        dcts   = 1'b1;
        #3;
        check("rst_busy", b0, 0);
        check("rst_grant", g0, 0);
        check("rst_xbar", x0, 0);
        check("rst_cur", c0, 0);
        check("rst_rts", r0, 0);

        // single request
        do_reset();
        step(5'b00010, 1);
        check("single_idle", b0, 0);
        step(5'b00010, 1);
        check("single_busy", b0, 1);
        check("single_cur", c0, 1);
        check("single_rts0", r0, 0);
        check("single_g0", g0, 0);
        check("single_x0", x0, 5'b00010);
        for (int i = 0; i < 4; i++) begin
            step(5'b00010, 1);
            check("single_grant", g0, (i % 2 == 0) ? 5'b00010 : 5'b00000);
            check("single_xbar", x0, 5'b00010);
        end

        // fairness and hold caps with all ports requesting
        do_reset();
        step(5'b11111, 1);
        for (int i = 0; i < 6; i++) begin
            step(5'b11111, 1);
            check("rr_gap", g1, 0);
            step(5'b11111, 1);
            check("rr_h1", g1, 32'(5'b00001 << (i % 5)));
            check("rr_h3", g3, 32'(5'b00001 << (i / 3)));
            check("rr_h0", g0, 5'b00001);
        end

        // hold cap with two requesters
        do_reset();
        step(5'b00101, 1);
        for (int i = 0; i < 7; i++) begin
            step(5'b00101, 1);
            check("cap_gap", g3, 0);
            step(5'b00101, 1);
            check("cap_h3", g3, exp3[i]);
            check("cap_h1", g1, (i % 2) ? 5'b00100 : 5'b00001);
            check("cap_h0", g0, 5'b00001);
        end
        for (int i = 0; i < 5; i++) begin
            step(5'b00001, 1);
            check("solo_gap", g3, 0);
            step(5'b00001, 1);
            check("solo_h3", g3, 5'b00001);
        end

        // backpressure
        do_reset();
        step(5'b00010, 0);
        step(5'b00010, 0);
        step(5'b00010, 0);
        check("bp_rts", r0, 1);
        check("bp_g", g0, 0);
        for (int i = 0; i < 5; i++) begin
            step(bp_req[i], 0);
            check("bp_rts_hold", r0, 1);
            check("bp_cur_hold", c0, 1);
            check("bp_xbar_hold", x0, 5'b00010);
            check("bp_no_grant", g0, 0);
        end
        step(5'b00000, 1);
        check("bp_grant", g0, 5'b00010);
        step(5'b00000, 1);
        check("bp_one_grant", g0, 0);
        check("bp_idle", b0, 0);

        // drain to idle, wrap, then async reset
        do_reset();
        step(5'b10000, 1);
        step(5'b10000, 1);
        check("drain_cur4", c0, 4);
        step(5'b00000, 1);
        check("drain_grant", g0, 5'b10000);
        step(5'b10001, 1);
        check("drain_idle", b0, 0);
        check("drain_cur", c0, 0);
        check("drain_xbar", x0, 0);
        step(5'b10001, 1);
        check("wrap_cur", c0, 0);
        check("wrap_xbar", x0, 5'b00001);
        step(5'b10001, 1);
        check("pre_rst_grant", g0, 5'b00001);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rts", r0, 0);
        check("arst_grant", g0, 0);
        check("arst_xbar", x0, 0);
        check("arst_busy", b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_param.md
# arbiter_rr_param

Parametrised round-robin output-port arbiter for the NoC router. It replaces the fixed five-port, fixed-priority-chain arbiter. One instance sits on each router output and selects one of `NUM_PORTS` input requesters. It drives the crossbar select and handles the RTS/DCTS flit handshake toward the downstream router. It adds true rotating priority and an optional cap on consecutive grants to one port (`MAX_HOLD`).

## Interface
- `NUM_PORTS`, default 5: number of requesters; must be 2..16. Index 0 = L, 1 = N, 2 = E, 3 = W, 4 = S in the default router.
- `MAX_HOLD`, default 0: maximum consecutive handshakes granted to one port while others request. 0 = unlimited.
- `IDX_W`, default $clog2(NUM_PORTS): derived; do not override.
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_PORTS: request per input port, level-sensitive.
- `dcts`  in  1: downstream clear-to-send.
- `grant`  out  NUM_PORTS: one-hot grant, combinational, equal to `(rts & dcts)` on the served bit.
- `xbar_sel`  out  NUM_PORTS: one-hot crossbar select of the served port; all zero in IDLE.
- `rts`  out  1: registered request-to-send toward downstream.
- `cur_port`  out  IDX_W: index of the served port; 0 in IDLE.
- `busy`  out  1: high when not in IDLE.

## Operation
- **State.** Registers are `mode` (IDLE/SERVE), `cur` (IDX_W), `rts`, `ptr` (IDX_W, round-robin start) and `hold_cnt` (width sufficient for MAX_HOLD).
- **Round-robin pick.**
  - `pick(start)` scans `req` from index `start` upward, modulo NUM_PORTS.
  - It returns the first set index. Otherwise it returns none.
- **IDLE.**
  - `rts` = 0. `grant` = 0. `xbar_sel` = 0.
  - If any `req` is set: go to SERVE, `cur` = pick(`ptr`), `hold_cnt` = 0.
- **SERVE, `rts` = 0.**
  - State holds.
  - `rts` goes to 1 at the next edge.
- **SERVE, `rts` = 1 and `dcts` = 0.**
  - Everything holds.
  - `rts` stays high even if `req[cur]` drops. There is no retraction.
- **SERVE, handshake (`rts` = 1 and `dcts` = 1).**
  - `grant[cur]` = 1 this cycle. `rts` goes to 0 at the next edge.
  - **Stay** (`cur` unchanged, `hold_cnt` + 1) when `req[cur]` = 1 and either:
    - `MAX_HOLD` = 0, or
    - `hold_cnt` + 1 < `MAX_HOLD`, or
    - no other `req` bit is set.
  - **Otherwise switch.**
    - `n` = pick(`cur` + 1 mod N). `cur` may be chosen again only if no other bit is set.
    - If `n` exists: `cur` = `n`, `hold_cnt` = 0, `ptr` = `n` + 1 mod N.
    - If none: go to IDLE, `ptr` = `cur` + 1 mod N, `hold_cnt` = 0.
- **Outputs in SERVE.** `xbar_sel` = one-hot(`cur`). `grant` = one-hot(`cur`) & {N{`rts & dcts`}}.
- **Saturation.** `hold_cnt` saturates at its maximum when `MAX_HOLD` = 0.

## Timing
- **Reset.** Asynchronous assertion forces `mode` = IDLE, `cur` = 0, `rts` = 0, `ptr` = 0, `hold_cnt` = 0. Therefore `grant` = 0, `xbar_sel` = 0, `busy` = 0, `cur_port` = 0.
  - Release is synchronous to `clk`. The first evaluation happens at the first edge after `rst_n` rises.
  - Reset mid-transfer drops `rts` immediately. No grant is issued.
- **Latency.** A `req` seen in IDLE at edge t gives SERVE at t. `rts` = 1 after edge t+1. Grant appears in the first cycle from t+1 onward with `dcts` = 1.
- **Throughput.** Peak is one handshake per 2 cycles, because `rts` always drops for one cycle after a handshake.
- **Switch timing.** On a port switch, `xbar_sel` changes at the same edge as `rts` falls. The new port's `rts` rises one edge later.
- **Simultaneous events.**
  - A `req` change in the handshake cycle is taken into the next-port decision.
  - `dcts` while `rts` = 0 is ignored.
- **Wrap-around.** `ptr` and `cur` + 1 wrap from NUM_PORTS−1 to 0.

## Test plan
- **Reset then single request.** Drive `req` = 00010, `dcts` = 1. Required: SERVE with `cur` = 1 one cycle after reset release, `rts` = 1 the cycle after, `grant` = 00010 pulses every 2 cycles, `xbar_sel` = 00010 steady.
- **Round-robin fairness.** `req` = 11111, `dcts` = 1, `MAX_HOLD` = 1. Required: grant order ports 0, 1, 2, 3, 4, 0, with each port granted exactly once per 10 cycles.
- **Hold cap.** `MAX_HOLD` = 3, `req` = 00101, `dcts` = 1. Required: three grants to port 0, then three to port 2, then port 0 again.
  - With `req` = 00001 only, port 0 is granted indefinitely.
- **Backpressure.** In SERVE with `rts` = 1, hold `dcts` = 0 for 5 cycles while changing `req`. Required: `rts`, `cur` and `xbar_sel` frozen, `grant` = 0. Then `dcts` = 1 gives exactly one grant.
- **Drain to idle and wrap.** Serve port 4, then drop all `req` at the handshake. Required: IDLE next edge, `busy` = 0, `ptr` = 0. Then `req` = 10001 selects port 0.
- **Async reset mid-operation.** Pull `rst_n` low mid-cycle while `rts` = 1. Required: `rts`, `grant` and `xbar_sel` go to 0 without waiting for a clock edge.
